// File: rtl/mem_pkg.sv
// Shared widths and types for the 128 x 8 scratch RAM.
package mem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    // Depth always follows the address width so every address is in range.
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : mem_pkg

// File: rtl/mem_if.sv
// Bus bundle for the scratch RAM: shared address, write data/enable, read data.
interface mem_if;
    import mem_pkg::*;

    addr_t adr;
    word_t dataIN;
    logic  we;
    word_t dataOUT;

    // Requester side: drives address/write data, observes read data.
    modport master (
        output adr,
        output dataIN,
        output we,
        input  dataOUT
    );

    // RAM side.
    modport slave (
        input  adr,
        input  dataIN,
        input  we,
        output dataOUT
    );

endinterface : mem_if

// File: rtl/mem.sv
// Single-port 128 x 8 RAM: synchronous write on ck, combinational read,
// asynchronous active-high reset that clears every word.
module mem
    import mem_pkg::*;
(
    input  logic    ck,
    input  logic    rst,
    mem_if.slave    bus
);

    word_t r_mem [DEPTH];
    word_t w_rd_word;

    // Array update: reset clears all words at once and overrides any write in flight.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.we) begin
            r_mem[bus.adr] <= bus.dataIN;
        end
    end

    // Combinational read; forced to 0 while reset is held so the output is
    // clean even before the array has ever been cleared.
    always_comb begin
        w_rd_word = r_mem[bus.adr];
        if (rst) begin
            w_rd_word = '0;
        end
    end

    assign bus.dataOUT = w_rd_word;

endmodule : mem

// File: tb/tb_mem.sv
// Directed bench for the scratch RAM.
module tb_mem;
    import mem_pkg::*;

    logic ck;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_if bus ();

    mem u_dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.slave)
    );

    initial ck = 1'b0;
    always #10 ck = ~ck;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic read_check(input string tag, input int a, input word_t exp);
        bus.adr = addr_t'(a);
        #1;
        check(tag, bus.dataOUT, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.adr    = '0;
        bus.dataIN = '0;
        bus.we     = 1'b0;

        #1;
        check("during_reset", bus.dataOUT, 8'h00);
        #14;
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) begin
            read_check("reset_sweep", a, 8'h00);
        end

        // Basic write.
        @(negedge ck);
        bus.adr = 7'd2; bus.dataIN = 8'd22; bus.we = 1'b1;
        @(negedge ck);
        bus.we = 1'b0;
        read_check("basic_wr_2", 2, 8'd22);
        read_check("basic_other_0", 0, 8'h00);
        read_check("basic_other_1", 1, 8'h00);
        read_check("basic_other_3", 3, 8'h00);
        read_check("basic_other_127", 127, 8'h00);

        // Write-enable gating.
        @(negedge ck);
        bus.adr = 7'd4; bus.dataIN = 8'd44; bus.we = 1'b0;
        @(negedge ck);
        read_check("we_low_4", 4, 8'h00);
        bus.we = 1'b1;
        @(negedge ck);
        bus.we = 1'b0;
        read_check("we_high_4", 4, 8'd44);

        // No write without we.
        bus.adr = 7'd6; bus.dataIN = 8'd66;
        repeat (2) @(negedge ck);
        bus.adr = 7'd7; bus.dataIN = 8'd77;
        repeat (2) @(negedge ck);
        read_check("nowr_7", 7, 8'h00);
        read_check("nowr_6", 6, 8'h00);
        bus.adr = 7'd7; bus.dataIN = 8'd77; bus.we = 1'b1;
        @(negedge ck);
        bus.we = 1'b0;
        read_check("wr_7", 7, 8'd77);

        // Read-during-write on the same address: old word until the edge.
        @(negedge ck);
        bus.adr = 7'd8; bus.dataIN = 8'h11; bus.we = 1'b1;
        #1;
        check("rdw_before_edge", bus.dataOUT, 8'h00);
        @(posedge ck);
        #1;
        check("rdw_after_edge", bus.dataOUT, 8'h11);
        bus.we = 1'b0;

        // Asynchronous read between edges.
        @(posedge ck);
        #2;
        read_check("async_6", 6, 8'h00);
        read_check("async_4", 4, 8'd44);
        read_check("async_7", 7, 8'd77);

        // Reset in the middle of a write cycle.
        @(negedge ck);
        bus.adr = 7'd10; bus.dataIN = 8'hA5; bus.we = 1'b1;
        @(negedge ck);
        bus.we = 1'b0;
        read_check("pre_rst_10", 10, 8'hA5);
        @(posedge ck);
        #3;
        bus.dataIN = 8'h3C; bus.we = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_immediate", bus.dataOUT, 8'h00);
        @(posedge ck);
        #1;
        check("rst_blocks_write", bus.dataOUT, 8'h00);
        @(negedge ck);
        bus.we = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_10", bus.dataOUT, 8'h00);
        read_check("post_rst_2", 2, 8'h00);
        read_check("post_rst_7", 7, 8'h00);
        @(negedge ck);
        read_check("post_rst_10_later", 10, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem
